// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered ARM decode control unit feeding the ID/EX boundary.
// Decodes {mode, opcode, S} into exe/mem/wb controls with a one-cycle latency.
// Handles valid/ready, hazard bubbles, flush, condition kill and a MEM_WAIT
// stall after LDR/STR.
// Optional feature macro: UNDEF_TRAP_EN adds a registered 'undef' output and
// zeroes the controls of unlisted encodings.
module ctrl_unit_pipe #(
  parameter int EXE_CMD_W = 4,
  parameter int MEM_LAT   = 0,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 s_bit,
  input  logic [1:0]           mode,
  input  logic [3:0]           opcode,
  input  logic                 cond_pass,
  input  logic                 hazard,
  input  logic                 flush,
  output logic                 valid_out,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 branch,
  output logic                 stat_update,
  output logic                 move,
  output logic                 busy
`ifdef UNDEF_TRAP_EN
  ,
  output logic                 undef
`endif
);

`ifdef UNDEF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       stat_update;
    logic       move;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  ctrl_t            ctl_q, ctl_d;
  logic             undef_q, undef_d;
  ctrl_t            dec, dec_raw;
  logic             dec_undef;

  // Combinational decode of the instruction fields
  always_comb begin
    dec_raw   = '0;
    dec_undef = 1'b0;
    case (mode)
      2'd0: begin
        dec_raw.stat_update = s_bit;
        dec_raw.wb_en       = 1'b1;
        case (opcode)
          4'd0:  dec_raw.cmd = 4'b0110;
          4'd1:  dec_raw.cmd = 4'b1000;
          4'd2:  dec_raw.cmd = 4'b0100;
          4'd4:  dec_raw.cmd = 4'b0010;
          4'd5:  dec_raw.cmd = 4'b0011;
          4'd6:  dec_raw.cmd = 4'b0101;
          4'd8:  begin dec_raw.cmd = 4'b0110; dec_raw.wb_en = 1'b0; end
          4'd10: begin dec_raw.cmd = 4'b0100; dec_raw.wb_en = 1'b0; end
          4'd12: dec_raw.cmd = 4'b0111;
          4'd13: begin dec_raw.cmd = 4'b0001; dec_raw.move = 1'b1; end
          4'd15: begin dec_raw.cmd = 4'b1001; dec_raw.move = 1'b1; end
          default: begin dec_raw.wb_en = 1'b0; dec_undef = 1'b1; end
        endcase
      end
      2'd1: begin
        if (opcode == 4'd4) begin
          dec_raw.cmd = 4'b0010;
          if (s_bit) begin
            dec_raw.mem_read = 1'b1;
            dec_raw.wb_en    = 1'b1;
          end else begin
            dec_raw.mem_write = 1'b1;
          end
        end else begin
          dec_undef = 1'b1;
        end
      end
      2'd2:    dec_raw.branch = 1'b1;
      default: dec_undef = 1'b1;
    endcase
    dec = (TRAP && dec_undef) ? '0 : dec_raw;
  end

  // Next-state: flush > MEM_WAIT > hazard > condition kill > accept > idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    ctl_d   = '0;
    undef_d = 1'b0;
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == MEM_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1)) state_d = RUN;
    end else if (valid_in && hazard) begin
      vld_d = 1'b0;
    end else if (valid_in && !cond_pass) begin
      vld_d = 1'b1;
    end else if (valid_in) begin
      vld_d   = 1'b1;
      ctl_d   = dec;
      undef_d = TRAP && dec_undef;
      if ((dec.mem_read || dec.mem_write) && (MEM_LAT > 0)) begin
        state_d = MEM_WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
      end
    end
  end

  // ID/EX boundary register and occupancy FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ctl_q   <= '0;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ctl_q   <= ctl_d;
      undef_q <= undef_d;
    end
  end

  assign ready_out   = !rst && !flush && (state_q == RUN) && !hazard;
  assign busy        = (state_q == MEM_WAIT);
  assign valid_out   = vld_q;
  assign exe_cmd     = EXE_CMD_W'(ctl_q.cmd);
  assign mem_read    = ctl_q.mem_read;
  assign mem_write   = ctl_q.mem_write;
  assign wb_en       = ctl_q.wb_en;
  assign branch      = ctl_q.branch;
  assign stat_update = ctl_q.stat_update;
  assign move        = ctl_q.move;
`ifdef UNDEF_TRAP_EN
  assign undef       = undef_q;
`else
  logic unused_undef;
  assign unused_undef = undef_q;
`endif

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: directed vectors against two instances (MEM_LAT=3 and 0).
module tb_ctrl_unit_pipe;
  logic       clk = 1'b0;
  logic       rst, valid_in, s_bit, cond_pass, hazard, flush;
  logic [1:0] mode;
  logic [3:0] opcode;

  logic       rdy3, vo3, mr3, mw3, wb3, br3, su3, mv3, busy3;
  logic [3:0] ec3;
  logic       rdy0, vo0, mr0, mw0, wb0, br0, su0, mv0, busy0;
  logic [3:0] ec0;
`ifdef UNDEF_TRAP_EN
  logic       ud3, ud0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_unit_pipe #(.EXE_CMD_W(4), .MEM_LAT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy3), .s_bit(s_bit),
    .mode(mode), .opcode(opcode), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
    .valid_out(vo3), .exe_cmd(ec3), .mem_read(mr3), .mem_write(mw3), .wb_en(wb3),
    .branch(br3), .stat_update(su3), .move(mv3), .busy(busy3)
`ifdef UNDEF_TRAP_EN
    , .undef(ud3)
`endif
  );

  ctrl_unit_pipe #(.EXE_CMD_W(4), .MEM_LAT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy0), .s_bit(s_bit),
    .mode(mode), .opcode(opcode), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
    .valid_out(vo0), .exe_cmd(ec0), .mem_read(mr0), .mem_write(mw0), .wb_en(wb0),
    .branch(br0), .stat_update(su0), .move(mv0), .busy(busy0)
`ifdef UNDEF_TRAP_EN
    , .undef(ud0)
`endif
  );

  // packed view {valid, cmd, mem_read, mem_write, wb_en, branch, stat_update, move}
  wire [10:0] o3 = {vo3, ec3, mr3, mw3, wb3, br3, su3, mv3};
  wire [10:0] o0 = {vo0, ec0, mr0, mw0, wb0, br0, su0, mv0};

  function automatic logic [10:0] ex(input logic v, input logic [3:0] c, input logic r,
                                     input logic w, input logic b, input logic br,
                                     input logic s, input logic m);
    return {v, c, r, w, b, br, s, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] m, input logic [3:0] op,
                     input logic s, input logic cp);
    valid_in = v; mode = m; opcode = op; s_bit = s; cond_pass = cp;
    #1;
  endtask

  logic [3:0] ops  [11] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd13, 4'd15};
  logic [3:0] cmds [11] = '{4'h6, 4'h8, 4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h4, 4'h7, 4'h1, 4'h9};
  logic       wbs  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       mvs  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; hazard = 1'b0; flush = 1'b0;
    drv(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    chk("rst_ready", {31'd0, rdy3}, 32'd0);
    step();
    chk("rst_out", {21'd0, o3}, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd0);
    rst = 1'b0;

    // ADD with S=1
    drv(1'b1, 2'd0, 4'd4, 1'b1, 1'b1);
    chk("ready_run", {31'd0, rdy3}, 32'd1);
    step();
    chk("add_s", {21'd0, o3}, {21'd0, ex(1, 4'h2, 0, 0, 1, 0, 1, 0)});

    // mode-0 sweep, S=0, back to back
    for (int i = 0; i < 11; i++) begin
      drv(1'b1, 2'd0, ops[i], 1'b0, 1'b1);
      step();
      chk($sformatf("sweep_op%0d", ops[i]), {21'd0, o3},
          {21'd0, ex(1, cmds[i], 0, 0, wbs[i], 0, 0, mvs[i])});
    end

    // TST with S=1 keeps stat_update
    drv(1'b1, 2'd0, 4'd8, 1'b1, 1'b1);
    step();
    chk("tst_s", {21'd0, o3}, {21'd0, ex(1, 4'h6, 0, 0, 0, 0, 1, 0)});

    // unlisted mode-0 opcode
    drv(1'b1, 2'd0, 4'd3, 1'b1, 1'b1);
    step();
`ifdef UNDEF_TRAP_EN
    chk("undef_op3", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 0, 0)});
    chk("undef_pulse", {31'd0, ud3}, 32'd1);
    drv(1'b0, 2'd0, 4'd3, 1'b1, 1'b1);
    step();
    chk("undef_clear", {31'd0, ud3}, 32'd0);
    drv(1'b1, 2'd0, 4'd3, 1'b1, 1'b0);
    step();
    chk("undef_killed", {31'd0, ud3}, 32'd0);
    drv(1'b1, 2'd3, 4'd0, 1'b0, 1'b1);
    step();
    chk("undef_mode3", {31'd0, ud3}, 32'd1);
`else
    chk("nop_op3", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 1, 0)});
`endif

    // idle bubble
    drv(1'b0, 2'd0, 4'd4, 1'b0, 1'b1);
    step();
    chk("idle_bubble", {21'd0, o3}, 32'd0);

    // LDR then ADD held: 3 stall cycles, ADD on 5th edge
    drv(1'b1, 2'd1, 4'd4, 1'b1, 1'b1);
    step();
    chk("ldr_out", {21'd0, o3}, {21'd0, ex(1, 4'h2, 1, 0, 1, 0, 0, 0)});
    drv(1'b1, 2'd0, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ldr_busy%0d", i), {30'd0, busy3, rdy3}, 32'b10);
      step();
      chk($sformatf("ldr_bubble%0d", i), {21'd0, o3}, 32'd0);
    end
    chk("ldr_release", {30'd0, busy3, rdy3}, 32'b01);
    step();
    chk("add_after_ldr", {21'd0, o3}, {21'd0, ex(1, 4'h2, 0, 0, 1, 0, 0, 0)});

    // STR then flush on second busy cycle
    drv(1'b1, 2'd1, 4'd4, 1'b0, 1'b1);
    step();
    chk("str_out", {21'd0, o3}, {21'd0, ex(1, 4'h2, 0, 1, 0, 0, 0, 0)});
    drv(1'b1, 2'd0, 4'd4, 1'b0, 1'b1);
    step();
    chk("str_busy1", {31'd0, busy3}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, rdy3}, 32'd0);
    step();
    chk("flush_bubble", {21'd0, o3}, 32'd0);
    flush = 1'b0;
    drv(1'b0, 2'd0, 4'd4, 1'b0, 1'b1);
    chk("flush_release", {30'd0, busy3, rdy3}, 32'b01);
    step();
    chk("no_stale", {21'd0, o3}, 32'd0);

    // hazard for two cycles on MOV
    hazard = 1'b1;
    drv(1'b1, 2'd0, 4'd13, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("haz_ready%0d", i), {31'd0, rdy3}, 32'd0);
      step();
      chk($sformatf("haz_bubble%0d", i), {21'd0, o3}, 32'd0);
    end
    hazard = 1'b0;
    #1;
    step();
    chk("mov_after_haz", {21'd0, o3}, {21'd0, ex(1, 4'h1, 0, 0, 1, 0, 0, 1)});

    // condition kill on branch and on LDR
    drv(1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
    step();
    chk("b_killed", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 0, 0)});
    drv(1'b1, 2'd1, 4'd4, 1'b1, 1'b0);
    step();
    chk("ldr_killed", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 0, 0)});
    chk("ldr_killed_busy", {31'd0, busy3}, 32'd0);
    drv(1'b1, 2'd2, 4'd0, 1'b0, 1'b1);
    step();
    chk("b_taken", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 1, 0, 0)});

`ifndef UNDEF_TRAP_EN
    drv(1'b1, 2'd1, 4'd5, 1'b1, 1'b1);
    step();
    chk("mode1_other", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 0, 0)});
    drv(1'b1, 2'd3, 4'd4, 1'b1, 1'b1);
    step();
    chk("mode3", {21'd0, o3}, {21'd0, ex(1, 4'h0, 0, 0, 0, 0, 0, 0)});
`endif

    // MEM_LAT=0 instance takes back-to-back LDR
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(1'b1, 2'd1, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("lat0_ldr%0d", i), {21'd0, o0}, {21'd0, ex(1, 4'h2, 1, 0, 1, 0, 0, 0)});
      chk($sformatf("lat0_rdy%0d", i), {30'd0, busy0, rdy0}, 32'b01);
    end

    // reset during MEM_WAIT on the MEM_LAT=3 instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(1'b1, 2'd1, 4'd4, 1'b1, 1'b1);
    step();
    chk("pre_rst_busy", {31'd0, busy3}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_wait_out", {21'd0, o3}, 32'd0);
    chk("rst_wait_busy", {31'd0, busy3}, 32'd0);
    rst = 1'b0;
    drv(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    chk("rst_wait_ready", {31'd0, rdy3}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
